// File: rtl/hdlc_tx_shift.sv
// HDLC transmit shifter: parallel word -> LSB-first serial bits with zero-bit
// insertion, one bit per En strobe, fed through a one-word holding register.
module hdlc_tx_shift #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STUFF_RUN = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  logic             En,
    input  logic [WIDTH-1:0] PData,
    input  logic             PDataRaw,
    input  logic             PDataValid,
    output logic             PDataReady,
    output logic             SData,
    output logic             SDataValid,
    output logic             WordDone,
    output logic             Busy
);

    localparam int unsigned ONES_W = $clog2(STUFF_RUN + 1);
    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STUFF = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_raw_q, hold_raw_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               raw_q, raw_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ONES_W-1:0]  ones_cnt_q, ones_cnt_d;
    logic               after_last_q, after_last_d;
    logic               sdata_q, sdata_d;
    logic               sdata_valid_q, sdata_valid_d;
    logic               word_done_q, word_done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               bit_out;
    logic               stuff_req;
    logic               reload;

    // Bit leaving the shifter and whether it completes a run needing a stuffed 0
    assign bit_out   = shreg_q[0];
    assign stuff_req = !raw_q && bit_out && (ones_cnt_q == ONES_W'(STUFF_RUN - 1));

    // Next-state, datapath and output computation
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_raw_d    = hold_raw_q;
        hold_full_d   = hold_full_q;
        shreg_d       = shreg_q;
        raw_d         = raw_q;
        bit_cnt_d     = bit_cnt_q;
        ones_cnt_d    = ones_cnt_q;
        after_last_d  = after_last_q;
        sdata_d       = sdata_q;
        sdata_valid_d = 1'b0;
        word_done_d   = 1'b0;
        reload        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    reload  = 1'b1;
                    state_d = ST_SHIFT;
                end else if (En) begin
                    sdata_d    = 1'b1;
                    ones_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (En) begin
                    sdata_d       = bit_out;
                    shreg_d       = shreg_q >> 1;
                    sdata_valid_d = 1'b1;
                    if (raw_q || !bit_out || stuff_req) begin
                        ones_cnt_d = '0;
                    end else begin
                        ones_cnt_d = ones_cnt_q + ONES_W'(1);
                    end
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        word_done_d = 1'b1;
                        if (stuff_req) begin
                            state_d      = ST_STUFF;
                            after_last_d = 1'b1;
                        end else if (hold_full_q) begin
                            reload = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (stuff_req) begin
                            state_d      = ST_STUFF;
                            after_last_d = 1'b0;
                        end
                    end
                end
            end
            ST_STUFF: begin
                if (En) begin
                    sdata_d       = 1'b0;
                    sdata_valid_d = 1'b1;
                    ones_cnt_d    = '0;
                    if (!after_last_q) begin
                        state_d = ST_SHIFT;
                    end else if (hold_full_q) begin
                        reload  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Holding register to shifter transfer
        if (reload) begin
            shreg_d     = hold_q;
            raw_d       = hold_raw_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
        end

        // Upstream load; only possible while the hold is empty, so never with a transfer
        if (PDataValid && !hold_full_q) begin
            hold_d      = PData;
            hold_raw_d  = PDataRaw;
            hold_full_d = 1'b1;
        end

        ready_d = !hold_full_d;
        busy_d  = (state_d != ST_IDLE) || hold_full_d;
    end

    // State register with synchronous reset/clear
    always_ff @(posedge Clk) begin
        if (Rst || Clr) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            hold_raw_q    <= 1'b0;
            hold_full_q   <= 1'b0;
            shreg_q       <= '0;
            raw_q         <= 1'b0;
            bit_cnt_q     <= '0;
            ones_cnt_q    <= '0;
            after_last_q  <= 1'b0;
            sdata_q       <= 1'b1;
            sdata_valid_q <= 1'b0;
            word_done_q   <= 1'b0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_raw_q    <= hold_raw_d;
            hold_full_q   <= hold_full_d;
            shreg_q       <= shreg_d;
            raw_q         <= raw_d;
            bit_cnt_q     <= bit_cnt_d;
            ones_cnt_q    <= ones_cnt_d;
            after_last_q  <= after_last_d;
            sdata_q       <= sdata_d;
            sdata_valid_q <= sdata_valid_d;
            word_done_q   <= word_done_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
        end
    end

    assign PDataReady = ready_q;
    assign SData      = sdata_q;
    assign SDataValid = sdata_valid_q;
    assign WordDone   = word_done_q;
    assign Busy       = busy_q;

endmodule
